// File: rtl/relu_pkg.sv
// Shared constants and per-lane ReLU/requantise helper for relu_quant_stage.
// Saturation is selected at build time by the RELU_SAT_EN macro.
package relu_pkg;

  localparam int RELU_LANES = 32;
  localparam int RELU_IN_W  = 8;
  localparam int RELU_OUT_W = 4;
  localparam int RELU_SHIFT = 4;

  // Returns {flag, y}; y is right-aligned in bits [15:0].
  function automatic logic [16:0] relu_lane(
    input logic [63:0] x,
    input int          in_w,
    input int          out_w,
    input int          shift,
    input logic        sat
  );
    logic [63:0] m;
    logic [63:0] s;
    logic [63:0] mx;
    logic [16:0] r;
    m  = (64'd1 << in_w) - 64'd1;
    s  = (x & m) >> shift;
    mx = (64'd1 << (out_w - 1)) - 64'd1;
    r  = '0;
    if (!x[in_w-1]) begin
      if (sat && (s > mx)) begin
        r[16]   = 1'b1;
        r[15:0] = mx[15:0];
      end else begin
        r[15:0] = 16'(s & mx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_skid_fifo.sv
// Two-entry output buffer for relu_quant_stage.
// Ready and valid are decoded from the occupancy register only.
module relu_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [1:0]   cnt;
  logic [W-1:0] m0;
  logic [W-1:0] m1;
  logic         push;
  logic         pop;

  assign push_ready = (cnt != 2'd2);
  assign pop_valid  = (cnt != 2'd0);
  assign pop_data   = pop_valid ? m0 : '0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      m0  <= '0;
      m1  <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            m0  <= push_data;
            cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            m0 <= push_data;
          end else if (push) begin
            m1  <= push_data;
            cnt <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            m0  <= m1;
            cnt <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/relu_quant_stage.sv
// Pipelined ReLU + requantise stage with 2-entry output buffer.
// Define RELU_SAT_EN for saturate mode; otherwise truncate mode.
module relu_quant_stage
  import relu_pkg::*;
#(
  parameter int LANES = RELU_LANES,
  parameter int IN_W  = RELU_IN_W,
  parameter int OUT_W = RELU_OUT_W,
  parameter int SHIFT = RELU_SHIFT,
  parameter int ZC_W  = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*IN_W-1:0]  sum_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*OUT_W-1:0] act_out,
  output logic [ZC_W-1:0]        zero_cnt,
  output logic                   sat_any,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clr_stat,
  output logic                   sat_seen
);

  localparam int AW = LANES * OUT_W;
  localparam int FW = AW + ZC_W + 1;

`ifdef RELU_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  if (SHIFT + OUT_W - 1 > IN_W - 1) begin : g_bad_shift
    $error("relu_quant_stage: SHIFT + OUT_W - 1 exceeds IN_W - 1");
  end
  if (OUT_W < 2 || OUT_W > 15 || IN_W > 63) begin : g_bad_width
    $error("relu_quant_stage: unsupported OUT_W or IN_W");
  end

  logic [AW-1:0]    act_c;
  logic [LANES-1:0] flg;
  logic [LANES-1:0] zl;
  logic [ZC_W-1:0]  zc;
  logic             sat_c;
  logic             acc;
  logic [FW-1:0]    head;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [16:0] r;
    logic        hi_unused;
    assign r = relu_lane(64'(sum_in[i*IN_W +: IN_W]),
                         IN_W, OUT_W, SHIFT, SAT);
    assign act_c[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
    assign flg[i] = r[16];
    assign zl[i]  = (r[OUT_W-1:0] == '0);
    assign hi_unused = &{1'b0, r[15:OUT_W]};
  end

  always_comb begin
    zc = '0;
    for (int i = 0; i < LANES; i++) begin
      zc = zc + ZC_W'(zl[i]);
    end
  end

  assign sat_c = |flg;
  assign acc   = in_valid && in_ready;

  relu_skid_fifo #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(in_valid),
    .push_ready(in_ready),
    .push_data ({sat_c, zc, act_c}),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (head)
  );

  assign {sat_any, zero_cnt, act_out} = head;

`ifdef RELU_SAT_EN
  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_seen <= 1'b0;
    end else if (acc && sat_c) begin
      sat_seen <= 1'b1;
    end else if (clr_stat) begin
      sat_seen <= 1'b0;
    end
  end
`else
  logic clr_unused;
  assign clr_unused = clr_stat | acc;
  assign sat_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_relu_quant_stage.sv
// Self-checking bench for relu_quant_stage (default and 12-bit instances).
// Builds with or without RELU_SAT_EN.
module tb_relu_quant_stage;

`ifdef RELU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [127:0] act;
    int           zc;
    bit           sa;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] sum_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] act_out;
  logic [5:0]   zero_cnt;
  logic         sat_any;
  logic         out_valid;
  logic         out_ready;
  logic         clr_stat;
  logic         sat_seen;

  logic [47:0]  s_sum;
  logic         s_iv;
  logic         s_ir;
  logic [15:0]  s_act;
  logic [2:0]   s_zc;
  logic         s_sa;
  logic         s_ov;
  logic         s_or;
  logic         s_clr;
  logic         s_seen;

  int    total = 0;
  int    bad   = 0;
  int    sent;
  bit    last_acc;
  beat_t q[$];

  always #5 clk = ~clk;

  relu_quant_stage u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_in   (sum_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .act_out  (act_out),
    .zero_cnt (zero_cnt),
    .sat_any  (sat_any),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_stat (clr_stat),
    .sat_seen (sat_seen)
  );

  relu_quant_stage #(
    .LANES(4),
    .IN_W (12),
    .OUT_W(4),
    .SHIFT(4)
  ) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_in   (s_sum),
    .in_valid (s_iv),
    .in_ready (s_ir),
    .act_out  (s_act),
    .zero_cnt (s_zc),
    .sat_any  (s_sa),
    .out_valid(s_ov),
    .out_ready(s_or),
    .clr_stat (s_clr),
    .sat_seen (s_seen)
  );

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Arithmetic reference: clamp negatives, divide, then wrap or clamp.
  function automatic int ref_lane(input int x, input bit sat);
    int s;
    if (x < 0) return 0;
    s = x / 16;
    if (sat) return (s > 7) ? 7 : s;
    return s % 8;
  endfunction

  function automatic beat_t exp_beat(input logic [255:0] v);
    beat_t b;
    int    x;
    int    y;
    b.act = '0;
    b.zc  = 0;
    b.sa  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      x = int'($signed(v[i*8 +: 8]));
      y = ref_lane(x, SAT);
      b.act[i*4 +: 4] = 4'(y);
      if (y == 0) b.zc++;
      if (SAT && x >= 0 && x / 16 > 7) b.sa = 1'b1;
    end
    return b;
  endfunction

  task automatic tick();
    bit    pop;
    beat_t h;
    last_acc = in_valid && in_ready;
    pop      = out_valid && out_ready;
    if (pop) begin
      h = q.pop_front();
      chk("pop_act", act_out, h.act);
      chk("pop_zc", 128'(zero_cnt), 128'(h.zc));
      chk("pop_sat", 128'(sat_any), 128'(h.sa));
    end
    if (last_acc) q.push_back(exp_beat(sum_in));
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) tick();
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    sum_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stat  = 1'b0;
    s_sum     = '0;
    s_iv      = 1'b0;
    s_or      = 1'b1;
    s_clr     = 1'b0;
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_act", act_out, 128'(0));
    chk("rst_zc", 128'(zero_cnt), 128'(0));
    chk("rst_sat_any", 128'(sat_any), 128'(0));
    chk("rst_sat_seen", 128'(sat_seen), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Legacy equivalence
    sum_in        = '0;
    sum_in[7:0]   = 8'h75;
    sum_in[15:8]  = 8'h85;
    sum_in[23:16] = 8'h0F;
    in_valid      = 1'b1;
    out_ready     = 1'b1;
    chk("leg_pre_valid", 128'(out_valid), 128'(0));
    tick();
    in_valid = 1'b0;
    chk("leg_valid", 128'(out_valid), 128'(1));
    chk("leg_act", act_out, 128'h7);
    chk("leg_zc", 128'(zero_cnt), 128'(31));
    tick();

    // Saturation instance
    s_sum = 48'h200;
    s_iv  = 1'b1;
    @(posedge clk);
    #1;
    s_iv = 1'b0;
    chk("sat_valid", 128'(s_ov), 128'(1));
    chk("sat_act", 128'(s_act), SAT ? 128'h7 : 128'h0);
    chk("sat_zc", 128'(s_zc), SAT ? 128'(3) : 128'(4));
    chk("sat_any", 128'(s_sa), 128'(SAT));
    chk("sat_seen", 128'(s_seen), 128'(SAT));
    @(posedge clk);
    #1;
    chk("sat_drained", 128'(s_ov), 128'(0));
    s_clr = 1'b1;
    s_iv  = 1'b1;
    @(posedge clk);
    #1;
    s_iv = 1'b0;
    chk("clr_set_wins", 128'(s_seen), 128'(SAT));
    @(posedge clk);
    #1;
    s_clr = 1'b0;
    chk("clr_alone", 128'(s_seen), 128'(0));

    // Back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = {32{8'h11}};
    tick();
    sum_in = {32{8'h22}};
    tick();
    chk("bp_full", 128'(in_ready), 128'(0));
    sum_in = {32{8'h33}};
    tick();
    tick();
    chk("bp_c_held", 128'(last_acc), 128'(0));
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    tick();
    chk("bp_c_taken", 128'(last_acc), 128'(1));
    in_valid = 1'b0;
    drain();

    // Random streaming
    sent = 0;
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      in_valid = ($urandom % 4) != 0;
      for (int k = 0; k < 8; k++) sum_in[k*32 +: 32] = $urandom;
      out_ready = ($urandom % 2) != 0;
      tick();
      if (last_acc) sent++;
    end
    chk("stream_sent", 128'(sent), 128'(100));
    drain();
    chk("main_sat_seen", 128'(sat_seen), 128'(0));

    // Reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = {32{8'h44}};
    tick();
    tick();
    in_valid = 1'b0;
    chk("rst_mid_full", 128'(in_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("rstm_out_valid", 128'(out_valid), 128'(0));
    chk("rstm_in_ready", 128'(in_ready), 128'(1));
    chk("rstm_act", act_out, 128'(0));
    chk("rstm_zc", 128'(zero_cnt), 128'(0));
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sum_in    = {32{8'h55}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_lat", 128'(out_valid), 128'(1));
    chk("rst_act_new", act_out, {32{4'h5}});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
